// File: rtl/usb_tx_encoder_if.sv
// Byte handshake between the TX byte FIFO (master) and the USB line encoder (slave).
interface usb_tx_encoder_if;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_byte_ready;

   modport master (
      output tx_data,
      output tx_data_valid,
      input  tx_byte_ready
   );

   modport slave (
      input  tx_data,
      input  tx_data_valid,
      output tx_byte_ready
   );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, NRZI with bit stuffing, EOP.
module usb_tx_encoder #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   usb_tx_encoder_if.slave fifo,
   output logic            dp_out,
   output logic            dm_out,
   output logic            tx_oe,
   output logic            tx_busy
);

   localparam int unsigned    TW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] ONE_TICK  = TW'(1);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

   state_t        state;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_cnt;
   logic [2:0]    ones;
   logic [7:0]    shift;
   logic          level;        // NRZI level, 1 = J
   logic          byte_ready;
   logic          boundary;
   logic          stuff;
   logic          do_send;
   logic          next_bit;
   logic          next_level;

   assign boundary          = (bit_timer == LAST_TICK);
   assign stuff             = (ones == 3'd6);
   assign next_level        = next_bit ? level : ~level;
   assign fifo.tx_byte_ready = byte_ready;

   // Choose the bit to put on the line at this edge, if any.
   always_comb begin
      next_bit = 1'b0;
      do_send  = 1'b0;
      case (state)
         IDLE: do_send = fifo.tx_data_valid;
         SYNC, DATA: begin
            if (boundary) begin
               do_send = 1'b1;
               if (state == DATA && stuff) begin
                  next_bit = 1'b0;
               end else if (bit_cnt == 3'd7) begin
                  // byte boundary: a new byte only if the FIFO has one, else EOP
                  next_bit = fifo.tx_data[0];
                  do_send  = fifo.tx_data_valid;
               end else if (state == SYNC) begin
                  next_bit = (bit_cnt == 3'd6);
               end else begin
                  next_bit = shift[1];
               end
            end
         end
         default: ;
      endcase
   end

   // Packet FSM with registered line outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_timer  <= '0;
         bit_cnt    <= '0;
         ones       <= '0;
         shift      <= '0;
         level      <= 1'b1;
         byte_ready <= 1'b0;
         dp_out     <= 1'b1;
         dm_out     <= 1'b0;
         tx_oe      <= 1'b0;
         tx_busy    <= 1'b0;
      end else begin
         byte_ready <= 1'b0;
         if (state != IDLE) begin
            bit_timer <= boundary ? '0 : bit_timer + ONE_TICK;
         end
         case (state)
            IDLE: begin
               bit_timer <= '0;
               if (fifo.tx_data_valid) begin
                  state   <= SYNC;
                  bit_cnt <= '0;
                  tx_oe   <= 1'b1;
                  tx_busy <= 1'b1;
               end
            end
            SYNC, DATA: begin
               if (boundary && !(state == DATA && stuff)) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     if (fifo.tx_data_valid) begin
                        state      <= DATA;
                        shift      <= fifo.tx_data;
                        byte_ready <= 1'b1;
                     end else begin
                        state  <= EOP_SE0;
                        dp_out <= 1'b0;
                        dm_out <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shift   <= shift >> 1;
                  end
               end
            end
            EOP_SE0: begin
               if (boundary) begin
                  if (bit_cnt == 3'd1) begin
                     state  <= EOP_J;
                     level  <= 1'b1;
                     dp_out <= 1'b1;
                     dm_out <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            EOP_J: begin
               if (boundary) begin
                  state   <= IDLE;
                  ones    <= '0;
                  tx_oe   <= 1'b0;
                  tx_busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         // Stuffed bits keep the shift register and bit count frozen.
         if (do_send) begin
            level  <= next_level;
            dp_out <= next_level;
            dm_out <= ~next_level;
            ones   <= next_bit ? ones + 3'd1 : 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomized bench for usb_tx_encoder against a bit-list reference model.
module tb_usb_tx_encoder;

   localparam int CPB = 4;
   localparam int SYM_J   = 2;
   localparam int SYM_K   = 1;
   localparam int SYM_SE0 = 0;

   logic clk = 1'b0;
   logic rst;
   logic dp_out, dm_out, tx_oe, tx_busy;

   usb_tx_encoder_if fifo_if ();

   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .fifo    (fifo_if),
      .dp_out  (dp_out),
      .dm_out  (dm_out),
      .tx_oe   (tx_oe),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] pkt[$];
   logic [7:0] fifo_q[$];
   int         exp_sym[$];
   int         exp_rdy[$];
   int         last_len;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic fifo_update();
      fifo_if.tx_data_valid = (fifo_q.size() > 0);
      fifo_if.tx_data       = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   // Expected line symbols per bit time and bit index where each byte begins.
   task automatic build_model();
      int src[$];
      int first[$];
      int bits[$];
      int ones;
      int lvl;
      logic [7:0] b;
      exp_sym.delete();
      exp_rdy.delete();
      for (int i = 0; i < 8; i++) begin
         src.push_back(i == 7 ? 1 : 0);
         first.push_back(0);
      end
      foreach (pkt[i]) begin
         b = pkt[i];
         for (int k = 0; k < 8; k++) begin
            src.push_back(int'(b[k]));
            first.push_back(k == 0 ? 1 : 0);
         end
      end
      ones = 0;
      foreach (src[j]) begin
         if (first[j] == 1) exp_rdy.push_back(bits.size());
         bits.push_back(src[j]);
         ones = (src[j] == 1) ? ones + 1 : 0;
         if (ones == 6) begin
            bits.push_back(0);
            ones = 0;
         end
      end
      lvl = 1;
      foreach (bits[j]) begin
         if (bits[j] == 0) lvl = 1 - lvl;
         exp_sym.push_back(lvl == 1 ? SYM_J : SYM_K);
      end
      exp_sym.push_back(SYM_SE0);
      exp_sym.push_back(SYM_SE0);
      exp_sym.push_back(SYM_J);
   endtask

   // Offers pkt through the FIFO model and checks one whole packet on the line.
   task automatic run_packet(input string name);
      int got_sym[$];
      int got_rdy[$];
      int cyc;
      int started;
      int done;
      int busy_bad;
      int unstable;
      int idx;
      build_model();
      fifo_q = pkt;
      fifo_update();
      cyc = -1; started = 0; done = 0; busy_bad = 0; unstable = 0;
      for (int t = 0; t < 3000 && done == 0; t++) begin
         @(posedge clk);
         #1;
         if (tx_oe) begin
            cyc++;
            started = 1;
            got_sym.push_back(int'({dp_out, dm_out}));
         end else if (started == 1) begin
            done = 1;
         end
         if (tx_busy !== tx_oe) busy_bad++;
         if (fifo_if.tx_byte_ready) begin
            got_rdy.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_update();
         end
      end
      last_len = got_sym.size();
      check({name, "_done"}, done, 1);
      check({name, "_oe_len"}, got_sym.size(), exp_sym.size() * CPB);
      foreach (exp_sym[i]) begin
         idx = i * CPB + CPB / 2;
         check($sformatf("%s_sym%0d", name, i), idx < got_sym.size() ? got_sym[idx] : 7,
               exp_sym[i]);
      end
      foreach (got_sym[c]) begin
         if (got_sym[c] != got_sym[(c / CPB) * CPB]) unstable++;
      end
      check({name, "_midbit_change"}, unstable, 0);
      check({name, "_rdy_n"}, got_rdy.size(), exp_rdy.size());
      foreach (exp_rdy[i]) begin
         check($sformatf("%s_rdy%0d", name, i), i < got_rdy.size() ? got_rdy[i] : -2,
               exp_rdy[i] * CPB);
      end
      check({name, "_busy_eq_oe"}, busy_bad, 0);
      check({name, "_idle_line"}, {dp_out, dm_out}, SYM_J);
   endtask

   initial begin
      rst = 1'b1;
      fifo_q.delete();
      fifo_update();
      repeat (3) @(posedge clk);
      #1;
      check("rst_dp", dp_out, 1);
      check("rst_dm", dm_out, 0);
      check("rst_oe", tx_oe, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_rdy", fifo_if.tx_byte_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_oe", tx_oe, 0);

      pkt = '{8'h00};
      run_packet("p00");
      check("p00_oe_cycles", last_len, 76);

      pkt = '{8'hFF};
      run_packet("pff");
      check("pff_cycles", last_len, 20 * CPB);

      pkt = '{8'hA5, 8'h3C};
      run_packet("pa53c");

      pkt = '{8'h80, 8'h3F};
      run_packet("p803f");

      pkt = '{8'hFF, 8'hFF, 8'hFF};
      run_packet("pff3");

      for (int p = 0; p < 12; p++) begin
         int n;
         pkt.delete();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
         end
         run_packet($sformatf("rnd%0d", p));
      end

      // Reset during data bit 3 of the first byte.
      pkt = '{8'h5A, 8'hC3};
      fifo_q = pkt;
      fifo_update();
      begin
         int seen;
         seen = 0;
         for (int t = 0; t < 20 && seen == 0; t++) begin
            @(posedge clk);
            #1;
            if (tx_oe) seen = 1;
         end
         check("rst_test_start", seen, 1);
      end
      repeat (8 * CPB + 3 * CPB) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_dp", dp_out, 1);
      check("arst_dm", dm_out, 0);
      check("arst_oe", tx_oe, 0);
      check("arst_busy", tx_busy, 0);
      check("arst_rdy", fifo_if.tx_byte_ready, 0);
      fifo_q.delete();
      fifo_update();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_oe", tx_oe, 0);
      pkt = '{8'h12};
      run_packet("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clk cycles per USB bit time (48 MHz clk -> 12 Mb/s full speed); legal range 2..16.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_data  input  8  next packet byte from the TX byte FIFO; sent LSB first.
REQ-005 SHALL have port tx_data_valid  input  1  tx_data holds a byte available for transmission.
REQ-006 SHALL have port tx_byte_ready  output  1  one-cycle pulse: tx_data consumed on this edge; FIFO advances its read pointer.
REQ-007 SHALL have port dp_out  output  1  D+ line drive value.
REQ-008 SHALL have port dm_out  output  1  D- line drive value.
REQ-009 SHALL have port tx_oe  output  1  line driver enable; high from first SYNC bit through the final EOP J bit.
REQ-010 SHALL have port tx_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-012 SHALL maintain a bit-timer counting 0..CLKS_PER_BIT-1; a bit boundary is the edge where the timer is CLKS_PER_BIT-1; line outputs change only on bit boundaries, except on IDLE exit.
REQ-013 SHALL, in IDLE with tx_data_valid=1, on the next edge enter SYNC, assert tx_oe, clear the bit-timer, and drive the first SYNC bit.
REQ-014 SHALL drive line states J = (dp_out=1, dm_out=0), K = (0,1), SE0 = (0,0); idle and reset level is J.
REQ-015 SHALL NRZI-encode: bit 0 toggles the line between J and K; bit 1 holds the current level.
REQ-016 SHALL send SYNC as bits 0,0,0,0,0,0,0,1 in time order (line K J K J K J K K); SYNC bits count toward bit stuffing.
REQ-017 SHALL, at each boundary needing a new byte (end of SYNC or end of the 8th data bit), sample tx_data_valid: if 1, load tx_data, pulse tx_byte_ready on that edge, and begin its bit 0 with no gap; if 0, enter EOP_SE0.
REQ-018 SHALL keep a consecutive-ones counter (0..6); after six consecutive transmitted 1s, the next bit time SHALL carry a stuffed 0 (toggle), reset the counter, and pause the data shift one bit time.
REQ-019 SHALL let stuffing span byte boundaries and SHALL insert a pending stuffed bit after the last data bit before entering EOP_SE0.
REQ-020 SHALL clear the ones counter on any transmitted 0 (data or stuffed) and on entry to IDLE.
REQ-021 SHALL drive SE0 for exactly 2 bit times in EOP_SE0, then J for 1 bit time in EOP_J, then enter IDLE and deassert tx_oe and tx_busy on the same edge.
REQ-022 SHALL ignore tx_data_valid except at the sample points of REQ-013 and REQ-017; tx_byte_ready SHALL never pulse outside them.
REQ-023 SHALL start a packet no earlier than the edge after IDLE entry when tx_data_valid is still high (minimum 1 clk inter-packet gap).

Reset
REQ-024 SHALL, while rst=1, asynchronously force state=IDLE, dp_out=1, dm_out=0, tx_oe=0, tx_busy=0, tx_byte_ready=0, bit-timer=0, ones counter=0, NRZI level=J, shift register=0.
REQ-025 SHALL abort any in-flight packet on reset without sending EOP; the first packet after reset release SHALL begin with a full SYNC.

Verification
REQ-026 SHALL pass: byte 0x00 then valid low, CLKS_PER_BIT=4 -> line K J K J K J K K, J K J K J K J K, SE0 SE0 J; tx_oe high 76 cycles; one tx_byte_ready pulse.
REQ-027 SHALL pass: byte 0xFF alone -> after SYNC (ends K): K K K K K, stuffed J, J J J, SE0 SE0 J; 20 bit times total.
REQ-028 SHALL pass: bytes 0xA5, 0x3C with valid held, then valid low -> exactly two tx_byte_ready pulses 8 bit times apart; 0xA5 bits 1,0,1,0,0,1,0,1 with no gap before 0x3C; EOP follows 0x3C bit 7.
REQ-029 SHALL pass: bytes 0x80, 0x3F -> 0x80 bit 7 plus 0x3F bits 0..4 give six ones across the boundary; stuffed toggle inserted before 0x3F bit 5.
REQ-030 SHALL pass: rst=1 during DATA bit 3 -> same-cycle dp_out=1, dm_out=0, tx_oe=0, tx_busy=0; after release with valid=1, a fresh SYNC K J K J K J K K is sent.
